// File: rtl/regfile_scoreboard_pkg.sv
// Shared definitions for the register-busy scoreboard.
//   DEF_ADDR_W   : default register address width
//   DEF_NUM_REGS : default number of architectural registers (2**DEF_ADDR_W)
//   ZERO_REG     : index of the hardwired-zero register
//   wb_kind_e    : classification of a writeback in the current cycle
package regfile_scoreboard_pkg;

  localparam int unsigned DEF_ADDR_W   = 5;
  localparam int unsigned DEF_NUM_REGS = 1 << DEF_ADDR_W;
  localparam int unsigned ZERO_REG     = 0;

  typedef enum logic [1:0] {
    WB_NONE,   // no writeback, or ignored because of flush
    WB_CLEAR,  // writeback to a busy register: clears it
    WB_ERROR   // writeback to a non-busy register: raises wb_err
  } wb_kind_e;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback-side bundle for the register-busy scoreboard.
//   master : decode/writeback stage (drives flush, issue, writeback, queries)
//   slave  : scoreboard (drives issue_ready, rsX_busy, busy_vec,
//            busy_count, wb_err)
interface regfile_scoreboard_if
  import regfile_scoreboard_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned NUM_REGS = 2**ADDR_W
);

  logic                flush;
  logic                issue_valid;
  logic [ADDR_W-1:0]   issue_rd;
  logic                issue_ready;
  logic                wb_valid;
  logic [ADDR_W-1:0]   wb_rd;
  logic [ADDR_W-1:0]   rs1;
  logic [ADDR_W-1:0]   rs2;
  logic                rs1_busy;
  logic                rs2_busy;
  logic [NUM_REGS-1:0] busy_vec;
  logic [ADDR_W:0]     busy_count;
  logic                wb_err;

  modport master (
    output flush, issue_valid, issue_rd, wb_valid, wb_rd, rs1, rs2,
    input  issue_ready, rs1_busy, rs2_busy, busy_vec, busy_count, wb_err
  );

  modport slave (
    input  flush, issue_valid, issue_rd, wb_valid, wb_rd, rs1, rs2,
    output issue_ready, rs1_busy, rs2_busy, busy_vec, busy_count, wb_err
  );

endinterface

// File: rtl/regfile_scoreboard_decoder_onehot.sv
// Enable-gated one-hot address decoder.
//   addr   : ADDR_W-bit register index
//   en     : when 0 the output is all zeros
//   onehot : 2**ADDR_W bits, bit addr set when en=1
module decoder_onehot
  import regfile_scoreboard_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic [ADDR_W-1:0]      addr,
  input  logic                   en,
  output logic [(2**ADDR_W)-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[addr] = 1'b1;
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register-busy scoreboard: one busy bit per architectural register, set
// when a writing instruction issues, cleared on its writeback.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   sb (slave)   : flush, issue handshake, writeback, two source queries,
//                  registered busy_vec/busy_count and sticky wb_err
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int unsigned ADDR_W         = DEF_ADDR_W,
  parameter int unsigned NUM_REGS       = 2**ADDR_W,
  parameter bit          ZERO_HARDWIRED = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  regfile_scoreboard_if.slave  sb
);

  localparam logic [ADDR_W:0] CNT_ONE = 1;

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [NUM_REGS-1:0] set_oh, clr_oh, busy_eff;
  logic [ADDR_W:0]     count_q, count_d;
  logic                err_q, err_d;
  logic                wb_hit, issue_fire, zero_issue, zero_wb;
  wb_kind_e            wb_kind;

  // The writeback bypass is applied to the query/ready outputs even during
  // flush; the state update below zeroes everything anyway.
  assign wb_hit = sb.wb_valid && busy_q[sb.wb_rd];

  decoder_onehot #(.ADDR_W(ADDR_W)) u_clr_dec (
    .addr   (sb.wb_rd),
    .en     (wb_hit),
    .onehot (clr_oh)
  );

  assign busy_eff       = busy_q & ~clr_oh;
  assign sb.issue_ready = !sb.flush && !busy_eff[sb.issue_rd];
  assign issue_fire     = sb.issue_valid && sb.issue_ready;

  decoder_onehot #(.ADDR_W(ADDR_W)) u_set_dec (
    .addr   (sb.issue_rd),
    .en     (issue_fire),
    .onehot (set_oh)
  );

  assign sb.rs1_busy = busy_eff[sb.rs1];
  assign sb.rs2_busy = busy_eff[sb.rs2];

  assign zero_issue = ZERO_HARDWIRED && (sb.issue_rd == ADDR_W'(ZERO_REG));
  assign zero_wb    = ZERO_HARDWIRED && (sb.wb_rd == ADDR_W'(ZERO_REG));

  always_comb begin
    wb_kind = WB_NONE;
    if (!sb.flush && sb.wb_valid) begin
      if (busy_q[sb.wb_rd]) wb_kind = WB_CLEAR;
      else if (!zero_wb)    wb_kind = WB_ERROR;
    end

    busy_d = (busy_q & ~clr_oh) | set_oh;
    if (ZERO_HARDWIRED) busy_d[ZERO_REG] = 1'b0;

    // Incremental popcount is exact: issue_ready guarantees the set target is
    // either idle or being cleared this same cycle (then +1/-1 cancel).
    count_d = count_q;
    if (issue_fire && !zero_issue) count_d = count_d + CNT_ONE;
    if (wb_kind == WB_CLEAR)       count_d = count_d - CNT_ONE;

    err_d = err_q || (wb_kind == WB_ERROR);

    if (sb.flush) begin
      busy_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign sb.busy_vec   = busy_q;
  assign sb.busy_count = count_q;
  assign sb.wb_err     = err_q;

endmodule
